// File: rtl/matmul_pkg.sv
// matmul_pkg: sequencer state encoding, default matrix dimensions and select-width helper
package matmul_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, FLUSH, DRAIN, DONE} state_t;

    localparam int DEF_NR      = 3;
    localparam int DEF_K       = 4;
    localparam int DEF_NC      = 3;
    localparam int DEF_MAC_LAT = 1;

    // Smallest select width that can address the largest of the A, B and C stores
    function automatic int idx_w(input int nr, input int k, input int nc);
        int m;
        m = nr * k;
        if (k * nc > m) m = k * nc;
        if (nr * nc > m) m = nr * nc;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    localparam int DEF_IDX_W = idx_w(DEF_NR, DEF_K, DEF_NC);
endpackage

// File: rtl/matmul_sequencer_if.sv
// matmul_sequencer_if: load strobes, operand selects, MAC control, result write and drain handshake
interface matmul_sequencer_if
    import matmul_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W
) ();
    logic             in_valid;
    logic             ld_a_we;
    logic             ld_b_we;
    logic [IDX_W-1:0] ld_sel;
    logic [IDX_W-1:0] a_sel;
    logic [IDX_W-1:0] b_sel;
    logic             mac_en;
    logic             mac_clr;
    logic             res_we;
    logic [IDX_W-1:0] res_idx;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_sel;

    modport master (
        input  in_valid, out_ready,
        output ld_a_we, ld_b_we, ld_sel, a_sel, b_sel, mac_en, mac_clr,
               res_we, res_idx, out_valid, out_sel
    );

    modport slave (
        output in_valid, out_ready,
        input  ld_a_we, ld_b_we, ld_sel, a_sel, b_sel, mac_en, mac_clr,
               res_we, res_idx, out_valid, out_sel
    );
endinterface

// File: rtl/nest_counter3.sv
// nest_counter3: i/j/k nested wrap counter (k innermost) with position flags for the sweep
module nest_counter3 #(
    parameter int NI = 3,
    parameter int NJ = 3,
    parameter int NK = 4,
    parameter int W  = 4
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_j,
    output logic         o_k_first,
    output logic         o_k_last,
    output logic         o_j_last,
    output logic         o_last
);
    logic [W-1:0] r_i;
    logic [W-1:0] r_j;
    logic [W-1:0] r_k;

    assign o_j       = r_j;
    assign o_k_first = r_k == '0;
    assign o_k_last  = r_k == W'(NK - 1);
    assign o_j_last  = r_j == W'(NJ - 1);
    assign o_last    = o_k_last && o_j_last && r_i == W'(NI - 1);

    // k steps every enabled cycle, j on k wrap, i on j wrap; clear parks all three at zero
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (i_en) begin
            r_k <= o_k_last ? '0 : r_k + 1'b1;
            if (o_k_last) r_j <= o_j_last ? '0 : r_j + 1'b1;
            if (o_k_last && o_j_last) r_i <= (r_i == W'(NI - 1)) ? '0 : r_i + 1'b1;
        end
    end
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: counter-driven load / compute / drain sequencer for a single-MAC matrix multiply
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int NR      = DEF_NR,
    parameter int K       = DEF_K,
    parameter int NC      = DEF_NC,
    parameter int IDX_W   = idx_w(NR, K, NC),
    parameter int MAC_LAT = DEF_MAC_LAT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_start,
    input  logic               i_abort,
    output logic               o_busy,
    output logic               o_done,
    matmul_sequencer_if.master bus
);
    localparam int NA  = NR * K;
    localparam int NB  = K * NC;
    localparam int NCR = NR * NC;

    state_t           r_state;
    logic [IDX_W-1:0] r_cnt;
    logic             r_ld_b;
    logic             r_busy;
    logic             r_done;
    logic             r_mac_en;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_a_sel;
    logic [IDX_W-1:0] r_b_sel;
    logic [IDX_W-1:0] r_res_cnt;
    logic [MAC_LAT-1:0] r_we_pipe;
    logic [IDX_W-1:0] r_idx_pipe [MAC_LAT];

    logic [IDX_W-1:0] w_j;
    logic             w_k_first;
    logic             w_k_last;
    logic             w_j_last;
    logic             w_last;
    logic             w_kill;
    logic             w_dp_clr;
    logic             w_ld_end;
    logic             w_op_done;

    // Reset always wins; abort only acts once a job is under way
    assign w_kill    = reset || (i_abort && r_state != IDLE);
    assign w_dp_clr  = w_kill || !r_mac_en;
    assign w_ld_end  = r_cnt == (r_ld_b ? IDX_W'(NB - 1) : IDX_W'(NA - 1));
    assign w_op_done = r_mac_en && w_k_last;

    nest_counter3 #(
        .NI (NR),
        .NJ (NC),
        .NK (K),
        .W  (IDX_W)
    ) u_cnt (
        .clk       (clk),
        .i_clr     (w_dp_clr),
        .i_en      (r_mac_en),
        .o_j       (w_j),
        .o_k_first (w_k_first),
        .o_k_last  (w_k_last),
        .o_j_last  (w_j_last),
        .o_last    (w_last)
    );

    // Job FSM; the flat counter serves as ld_sel in LOAD, flush timer in FLUSH and out_sel in DRAIN
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_ld_b      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_start) begin
                    r_state <= LOAD;
                    r_busy  <= 1'b1;
                end
                LOAD: if (bus.in_valid) begin
                    if (w_ld_end) begin
                        r_cnt  <= '0;
                        r_ld_b <= !r_ld_b;
                        if (r_ld_b) begin
                            r_state  <= COMPUTE;
                            r_mac_en <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                COMPUTE: if (w_last) begin
                    r_state  <= FLUSH;
                    r_mac_en <= 1'b0;
                end
                FLUSH: if (r_cnt == IDX_W'(MAC_LAT - 1)) begin
                    r_state     <= DRAIN;
                    r_cnt       <= '0;
                    r_out_valid <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                DRAIN: if (bus.out_ready) begin
                    if (r_cnt == IDX_W'(NCR - 1)) begin
                        r_state     <= DONE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Operand selects tracked by add/subtract steps alongside the i/j/k sweep
    always_ff @(posedge clk) begin
        if (w_dp_clr || w_last) begin
            r_a_sel   <= '0;
            r_b_sel   <= '0;
            r_res_cnt <= '0;
        end else if (w_k_last) begin
            r_a_sel   <= w_j_last ? r_a_sel + 1'b1 : r_a_sel - IDX_W'(K - 1);
            r_b_sel   <= w_j_last ? '0 : w_j + 1'b1;
            r_res_cnt <= r_res_cnt + 1'b1;
        end else begin
            r_a_sel <= r_a_sel + 1'b1;
            r_b_sel <= r_b_sel + IDX_W'(NC);
        end
    end

    // MAC_LAT-deep delay line carrying each finished sum's write strobe and result index
    always_ff @(posedge clk) begin
        if (w_kill) begin
            r_we_pipe <= '0;
            for (int n = 0; n < MAC_LAT; n++) r_idx_pipe[n] <= '0;
        end else begin
            r_we_pipe[0]  <= w_op_done;
            r_idx_pipe[0] <= w_op_done ? r_res_cnt : '0;
            for (int n = 1; n < MAC_LAT; n++) begin
                r_we_pipe[n]  <= r_we_pipe[n-1];
                r_idx_pipe[n] <= r_idx_pipe[n-1];
            end
        end
    end

    assign bus.ld_a_we   = r_state == LOAD && !r_ld_b && bus.in_valid;
    assign bus.ld_b_we   = r_state == LOAD && r_ld_b && bus.in_valid;
    assign bus.ld_sel    = (r_state == LOAD) ? r_cnt : '0;
    assign bus.a_sel     = r_a_sel;
    assign bus.b_sel     = r_b_sel;
    assign bus.mac_en    = r_mac_en;
    assign bus.mac_clr   = r_mac_en && w_k_first;
    assign bus.res_we    = r_we_pipe[MAC_LAT-1];
    assign bus.res_idx   = r_idx_pipe[MAC_LAT-1];
    assign bus.out_valid = r_out_valid;
    assign bus.out_sel   = (r_state == DRAIN) ? r_cnt : '0;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer: directed jobs checked every cycle against a job-level model of the sequencer
module tb_matmul_sequencer;
    localparam int NR      = 3;
    localparam int K       = 4;
    localparam int NC      = 3;
    localparam int IDX_W   = 4;
    localparam int MAC_LAT = 1;
    localparam int NA      = NR * K;
    localparam int NB      = K * NC;
    localparam int NOPS    = NR * NC * K;
    localparam int NRES    = NR * NC;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy;
    logic done;

    matmul_sequencer_if #(.IDX_W(IDX_W)) bus ();

    matmul_sequencer #(
        .NR      (NR),
        .K       (K),
        .NC      (NC),
        .IDX_W   (IDX_W),
        .MAC_LAT (MAC_LAT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (start),
        .i_abort (abort),
        .o_busy  (busy),
        .o_done  (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Job-level model: counts of words loaded, products issued, flush cycles and results accepted
    typedef enum {M_IDLE, M_LOAD, M_COMP, M_FLUSH, M_DRAIN, M_DONE} mph_t;
    mph_t ph = M_IDLE;
    int words = 0;
    int op = 0;
    int fl = 0;
    int acc = 0;
    int cyc = 0;
    int due_q[$];
    int idx_q[$];
    bit run = 1'b0;
    bit e_we;
    int e_idx;
    int res_cnt = 0;
    int done_cnt = 0;

    always @(negedge clk) if (run) begin
        e_we  = due_q.size() > 0 && due_q[0] == cyc;
        e_idx = e_we ? idx_q[0] : 0;
        if (e_we) begin
            void'(due_q.pop_front());
            void'(idx_q.pop_front());
        end
        chk("busy", busy, ph != M_IDLE);
        chk("done", done, ph == M_DONE);
        chk("ld_a_we", bus.ld_a_we, ph == M_LOAD && words < NA && bus.in_valid);
        chk("ld_b_we", bus.ld_b_we, ph == M_LOAD && words >= NA && bus.in_valid);
        if (ph == M_LOAD) chk("ld_sel", bus.ld_sel, words < NA ? words : words - NA);
        chk("mac_en", bus.mac_en, ph == M_COMP);
        chk("mac_clr", bus.mac_clr, ph == M_COMP && op % K == 0);
        if (ph == M_COMP) begin
            chk("a_sel", bus.a_sel, (op / (NC * K)) * K + op % K);
            chk("b_sel", bus.b_sel, (op % K) * NC + (op / K) % NC);
        end
        chk("res_we", bus.res_we, e_we);
        if (e_we) chk("res_idx", bus.res_idx, e_idx);
        chk("out_valid", bus.out_valid, ph == M_DRAIN);
        if (ph == M_DRAIN) chk("out_sel", bus.out_sel, acc);
        if (bus.res_we) res_cnt++;
        if (done) done_cnt++;
        if (reset || (abort && ph != M_IDLE)) begin
            ph = M_IDLE;
            due_q.delete();
            idx_q.delete();
        end else begin
            case (ph)
                M_IDLE: if (start) begin
                    ph = M_LOAD;
                    words = 0;
                end
                M_LOAD: if (bus.in_valid) begin
                    words++;
                    if (words == NA + NB) begin
                        ph = M_COMP;
                        op = 0;
                    end
                end
                M_COMP: begin
                    if (op % K == K - 1) begin
                        due_q.push_back(cyc + MAC_LAT);
                        idx_q.push_back(op / K);
                    end
                    op++;
                    if (op == NOPS) begin
                        ph = M_FLUSH;
                        fl = 0;
                    end
                end
                M_FLUSH: begin
                    fl++;
                    if (fl == MAC_LAT) begin
                        ph = M_DRAIN;
                        acc = 0;
                    end
                end
                M_DRAIN: if (bus.out_ready) begin
                    acc++;
                    if (acc == NRES) ph = M_DONE;
                end
                M_DONE: ph = M_IDLE;
                default: ;
            endcase
        end
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input bit gapped);
        for (int w = 0; w < NA + NB; w++) begin
            bus.in_valid = 1'b1;
            step(1);
            if (gapped) begin
                bus.in_valid = 1'b0;
                step(1);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic begin_job();
        res_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (!bus.out_valid && n < 120) begin
            step(1);
            n++;
        end
        chk("drain_reached", bus.out_valid, 1);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_mac_en"}, bus.mac_en, 0);
        chk({tag, "_ld_a_we"}, bus.ld_a_we, 0);
        chk({tag, "_res_we"}, bus.res_we, 0);
        chk({tag, "_res_idx"}, bus.res_idx, 0);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_out_sel"}, bus.out_sel, 0);
        chk({tag, "_a_sel"}, bus.a_sel, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        run = 1'b1;
        #1;
        step(2);
        chk_quiet("rst");
        reset = 1'b0;
        step(1);

        // full job, out_ready high throughout
        begin_job();
        load(1'b0);
        chk("c0_mac_en", bus.mac_en, 1);
        chk("c0_a_sel", bus.a_sel, 0);
        chk("c0_b_sel", bus.b_sel, 0);
        chk("c0_mac_clr", bus.mac_clr, 1);
        step(5);
        chk("c5_a_sel", bus.a_sel, 1);
        chk("c5_b_sel", bus.b_sel, 4);
        chk("c5_mac_clr", bus.mac_clr, 0);
        step(30);
        chk("c35_mac_en", bus.mac_en, 1);
        chk("c35_a_sel", bus.a_sel, 11);
        chk("c35_b_sel", bus.b_sel, 11);
        step(1);
        chk("c36_mac_en", bus.mac_en, 0);
        chk("c36_res_we", bus.res_we, 1);
        chk("c36_res_idx", bus.res_idx, 8);
        step(1);
        chk("d0_out_valid", bus.out_valid, 1);
        chk("d0_out_sel", bus.out_sel, 0);
        step(9);
        chk("d9_done", done, 1);
        step(1);
        chk("job1_idle", busy, 0);
        chk("job1_res_cnt", res_cnt, 9);
        chk("job1_done_cnt", done_cnt, 1);

        // gapped load, then backpressure at out_sel=4
        begin_job();
        load(1'b1);
        wait_drain();
        step(4);
        bus.out_ready = 1'b0;
        chk("bp_sel", bus.out_sel, 4);
        for (int c = 0; c < 3; c++) begin
            step(1);
            chk("bp_hold_sel", bus.out_sel, 4);
            chk("bp_hold_valid", bus.out_valid, 1);
        end
        bus.out_ready = 1'b1;
        step(5);
        chk("bp_done", done, 1);
        step(1);
        chk("job2_res_cnt", res_cnt, 9);
        chk("job2_done_cnt", done_cnt, 1);

        // abort at c0+10
        begin_job();
        load(1'b0);
        step(10);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_mac_en", bus.mac_en, 0);
        step(40);
        chk("abort_res_cnt", res_cnt, 2);
        chk("abort_done_cnt", done_cnt, 0);

        // clean rerun after abort
        begin_job();
        load(1'b0);
        step(46);
        chk("rerun_done", done, 1);
        step(1);
        chk("rerun_res_cnt", res_cnt, 9);
        chk("rerun_done_cnt", done_cnt, 1);

        // stray starts while busy, then reset mid-DRAIN
        begin_job();
        bus.in_valid = 1'b1;
        step(5);
        start = 1'b1;
        step(1);
        start = 1'b0;
        step(18);
        bus.in_valid = 1'b0;
        wait_drain();
        step(2);
        start = 1'b1;
        step(1);
        reset = 1'b1;
        step(1);
        start = 1'b0;
        reset = 1'b0;
        chk_quiet("mid_rst");
        step(3);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done_cnt", done_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
